// File: rtl/ibex_multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ibex_multdiv_sequencer
// Brief    : Request/response front end for the fast multiply/divide engine;
//            latches one M-extension op and sequences the engine to completion.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_multdiv_sequencer #(
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_op_i,
    input  logic [31:0]      req_a_i,
    input  logic [31:0]      req_b_i,
    input  logic             data_ind_timing_i,
    input  logic             flush_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [31:0]      resp_result_o,
    output logic             md_mult_en_o,
    output logic             md_div_en_o,
    output logic             md_mult_sel_o,
    output logic             md_div_sel_o,
    output logic [1:0]       md_operator_o,
    output logic [1:0]       md_signed_mode_o,
    output logic [31:0]      md_op_a_o,
    output logic [31:0]      md_op_b_o,
    output logic             md_equal_to_zero_o,
    output logic             md_data_ind_timing_o,
    output logic [67:0]      md_imd_val_q_o,
    input  logic [67:0]      md_imd_val_d_i,
    input  logic [1:0]       md_imd_val_we_i,
    output logic             md_ready_id_o,
    input  logic             md_valid_i,
    input  logic [31:0]      md_result_i,
    output logic [CNT_W-1:0] busy_cycles_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e            r_state_q, w_state_d;
    logic [1:0]        r_operator_q, w_operator_d, w_operator;
    logic [1:0]        r_mode_q, w_mode_d, w_mode;
    logic              r_mult_sel_q, w_mult_sel_d, r_div_sel_q, w_div_sel_d;
    logic              r_mult_en_q, w_mult_en_d, r_div_en_q, w_div_en_d;
    logic              r_ready_id_q, w_ready_id_d;
    logic              r_resp_valid_q, w_resp_valid_d;
    logic              r_eq_zero_q, w_eq_zero_d, r_dit_q, w_dit_d;
    logic [31:0]       r_op_a_q, w_op_a_d, r_op_b_q, w_op_b_d;
    logic [31:0]       r_result_q, w_result_d;
    logic [33:0]       r_imd0_q, w_imd0_d, r_imd1_q, w_imd1_d;
    logic [CNT_W-1:0]  r_cnt_q, w_cnt_d, r_busy_q, w_busy_d, w_cnt_inc;
    logic              w_accept;

    // A flush in RESP must not look like an accepted request to the producer.
    assign req_ready_o = (r_state_q == S_IDLE) |
                         ((r_state_q == S_RESP) & resp_ready_i & ~flush_i);
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_cnt_inc   = (&r_cnt_q) ? r_cnt_q : r_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        w_operator = 2'd0;
        w_mode     = 2'b00;
        case (req_op_i)
            3'd0:    begin w_operator = 2'd0; w_mode = 2'b00; end
            3'd1:    begin w_operator = 2'd1; w_mode = 2'b11; end
            3'd2:    begin w_operator = 2'd1; w_mode = 2'b01; end
            3'd3:    begin w_operator = 2'd1; w_mode = 2'b00; end
            3'd4:    begin w_operator = 2'd2; w_mode = 2'b11; end
            3'd5:    begin w_operator = 2'd2; w_mode = 2'b00; end
            3'd6:    begin w_operator = 2'd3; w_mode = 2'b11; end
            default: begin w_operator = 2'd3; w_mode = 2'b00; end
        endcase
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_operator_d   = r_operator_q;
        w_mode_d       = r_mode_q;
        w_mult_sel_d   = r_mult_sel_q;
        w_div_sel_d    = r_div_sel_q;
        w_mult_en_d    = r_mult_en_q;
        w_div_en_d     = r_div_en_q;
        w_ready_id_d   = r_ready_id_q;
        w_resp_valid_d = r_resp_valid_q;
        w_eq_zero_d    = r_eq_zero_q;
        w_dit_d        = r_dit_q;
        w_op_a_d       = r_op_a_q;
        w_op_b_d       = r_op_b_q;
        w_result_d     = r_result_q;
        w_cnt_d        = r_cnt_q;
        w_busy_d       = r_busy_q;
        w_imd0_d       = md_imd_val_we_i[0] ? md_imd_val_d_i[33:0]  : r_imd0_q;
        w_imd1_d       = md_imd_val_we_i[1] ? md_imd_val_d_i[67:34] : r_imd1_q;

        case (r_state_q)
            S_BUSY: begin
                w_cnt_d = w_cnt_inc;
                if (md_valid_i) begin
                    w_mult_en_d  = 1'b0;
                    w_div_en_d   = 1'b0;
                    w_ready_id_d = 1'b0;
                    if (flush_i) begin
                        w_state_d = S_IDLE;
                    end else begin
                        w_result_d     = md_result_i;
                        w_busy_d       = w_cnt_inc;
                        w_resp_valid_d = 1'b1;
                        w_state_d      = S_RESP;
                    end
                end else if (flush_i) begin
                    w_state_d = S_DRAIN;
                end
            end
            // Engine cannot be aborted, so keep it running until it reports done.
            S_DRAIN: begin
                if (md_valid_i) begin
                    w_mult_en_d  = 1'b0;
                    w_div_en_d   = 1'b0;
                    w_ready_id_d = 1'b0;
                    w_state_d    = S_IDLE;
                end
            end
            S_RESP: begin
                if (flush_i || resp_ready_i) begin
                    w_resp_valid_d = 1'b0;
                    w_state_d      = S_IDLE;
                end
            end
            default: ;
        endcase

        if (w_accept) begin
            w_state_d      = S_BUSY;
            w_operator_d   = w_operator;
            w_mode_d       = w_mode;
            w_mult_sel_d   = ~req_op_i[2];
            w_div_sel_d    = req_op_i[2];
            w_mult_en_d    = ~req_op_i[2];
            w_div_en_d     = req_op_i[2];
            w_ready_id_d   = 1'b1;
            w_resp_valid_d = 1'b0;
            w_eq_zero_d    = (req_b_i == 32'd0);
            w_dit_d        = data_ind_timing_i;
            w_op_a_d       = req_a_i;
            w_op_b_d       = req_b_i;
            w_cnt_d        = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q      <= S_IDLE;
            r_operator_q   <= 2'd0;
            r_mode_q       <= 2'b00;
            r_mult_sel_q   <= 1'b0;
            r_div_sel_q    <= 1'b0;
            r_mult_en_q    <= 1'b0;
            r_div_en_q     <= 1'b0;
            r_ready_id_q   <= 1'b0;
            r_resp_valid_q <= 1'b0;
            r_eq_zero_q    <= 1'b0;
            r_dit_q        <= 1'b0;
            r_op_a_q       <= 32'd0;
            r_op_b_q       <= 32'd0;
            r_result_q     <= 32'd0;
            r_cnt_q        <= '0;
            r_busy_q       <= '0;
            r_imd0_q       <= 34'd0;
            r_imd1_q       <= 34'd0;
        end else begin
            r_state_q      <= w_state_d;
            r_operator_q   <= w_operator_d;
            r_mode_q       <= w_mode_d;
            r_mult_sel_q   <= w_mult_sel_d;
            r_div_sel_q    <= w_div_sel_d;
            r_mult_en_q    <= w_mult_en_d;
            r_div_en_q     <= w_div_en_d;
            r_ready_id_q   <= w_ready_id_d;
            r_resp_valid_q <= w_resp_valid_d;
            r_eq_zero_q    <= w_eq_zero_d;
            r_dit_q        <= w_dit_d;
            r_op_a_q       <= w_op_a_d;
            r_op_b_q       <= w_op_b_d;
            r_result_q     <= w_result_d;
            r_cnt_q        <= w_cnt_d;
            r_busy_q       <= w_busy_d;
            r_imd0_q       <= w_imd0_d;
            r_imd1_q       <= w_imd1_d;
        end
    end

    assign resp_valid_o         = r_resp_valid_q;
    assign resp_result_o        = r_result_q;
    assign md_mult_en_o         = r_mult_en_q;
    assign md_div_en_o          = r_div_en_q;
    assign md_mult_sel_o        = r_mult_sel_q;
    assign md_div_sel_o         = r_div_sel_q;
    assign md_operator_o        = r_operator_q;
    assign md_signed_mode_o     = r_mode_q;
    assign md_op_a_o            = r_op_a_q;
    assign md_op_b_o            = r_op_b_q;
    assign md_equal_to_zero_o   = r_eq_zero_q;
    assign md_data_ind_timing_o = r_dit_q;
    assign md_imd_val_q_o       = {r_imd1_q, r_imd0_q};
    assign md_ready_id_o        = r_ready_id_q;
    assign busy_cycles_o        = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ibex_multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_multdiv_sequencer
// Brief    : Directed vector bench with a behavioural engine model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_multdiv_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0, req_ready_o;
    logic [2:0]  req_op_i = 3'd0;
    logic [31:0] req_a_i = 32'd0, req_b_i = 32'd0;
    logic        data_ind_timing_i = 1'b0, flush_i = 1'b0;
    logic        resp_valid_o, resp_ready_i = 1'b0;
    logic [31:0] resp_result_o;
    logic        md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o;
    logic [1:0]  md_operator_o, md_signed_mode_o;
    logic [31:0] md_op_a_o, md_op_b_o;
    logic        md_equal_to_zero_o, md_data_ind_timing_o;
    logic [67:0] md_imd_val_q_o, md_imd_val_d_i = 68'd0;
    logic [1:0]  md_imd_val_we_i = 2'b00;
    logic        md_ready_id_o, md_valid_i;
    logic [31:0] md_result_i;
    logic [5:0]  busy_cycles_o;

    ibex_multdiv_sequencer #(.CNT_W(6)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .data_ind_timing_i(data_ind_timing_i),
        .flush_i(flush_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_result_o(resp_result_o), .md_mult_en_o(md_mult_en_o), .md_div_en_o(md_div_en_o),
        .md_mult_sel_o(md_mult_sel_o), .md_div_sel_o(md_div_sel_o),
        .md_operator_o(md_operator_o), .md_signed_mode_o(md_signed_mode_o),
        .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o),
        .md_equal_to_zero_o(md_equal_to_zero_o), .md_data_ind_timing_o(md_data_ind_timing_o),
        .md_imd_val_q_o(md_imd_val_q_o), .md_imd_val_d_i(md_imd_val_d_i),
        .md_imd_val_we_i(md_imd_val_we_i), .md_ready_id_o(md_ready_id_o),
        .md_valid_i(md_valid_i), .md_result_i(md_result_i), .busy_cycles_o(busy_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    // Engine model: computes from the operator/mode/operands it is handed.
    function automatic logic [31:0] eng_calc(input logic [1:0] opr, input logic [1:0] mode,
                                             input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        logic [31:0] r;
        sa = mode[0] ? {{32{a[31]}}, a} : {32'd0, a};
        sb = mode[1] ? {{32{b[31]}}, b} : {32'd0, b};
        p  = sa * sb;
        case (opr)
            2'd0: r = p[31:0];
            2'd1: r = p[63:32];
            2'd2: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (mode[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else if (mode[0]) r = $signed(a) / $signed(b);
                else r = a / b;
            end
            default: begin
                if (b == 32'd0) r = a;
                else if (mode[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else if (mode[0]) r = $signed(a) % $signed(b);
                else r = a % b;
            end
        endcase
        return r;
    endfunction

    logic [5:0] eng_cnt, eng_lat;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) eng_cnt <= 6'd0;
        else if (md_mult_en_o || md_div_en_o) eng_cnt <= eng_cnt + 6'd1;
        else eng_cnt <= 6'd0;
    end
    assign eng_lat = (md_operator_o == 2'd0) ? 6'd3 :
                     (md_operator_o == 2'd1) ? 6'd4 :
                     (md_equal_to_zero_o && !md_data_ind_timing_o) ? 6'd2 : 6'd37;
    assign md_valid_i  = (md_mult_en_o || md_div_en_o) && (eng_cnt == eng_lat - 6'd1);
    assign md_result_i = eng_calc(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);

    int n_chk = 0, n_pass = 0;

    task automatic check(input string nm, input logic [67:0] act, input logic [67:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Presents a request and returns 1ns after the accepting edge (first BUSY cycle).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic dit);
        int n = 0;
        req_op_i = op; req_a_i = a; req_b_i = b; data_ind_timing_i = dit;
        req_valid_i = 1'b1;
        while (!req_ready_o && n < 100) begin @(negedge clk_i); n++; end
        check("req_ready_at_issue", 68'(req_ready_o), 68'd1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_resp(input int lat, input logic [31:0] res, input string nm);
        int cyc = 1;
        @(negedge clk_i);
        while (!resp_valid_o && cyc < 60) begin @(negedge clk_i); cyc++; end
        check({nm, "_latency"}, 68'(cyc), 68'(lat + 1));
        check({nm, "_result"}, 68'(resp_result_o), 68'(res));
        check({nm, "_busy_cycles"}, 68'(busy_cycles_o), 68'(lat));
    endtask

    task automatic finish_resp();
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
        check("resp_released", 68'(resp_valid_o), 68'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        dit;
        logic [31:0] res;
        int          lat;
    } vec_t;
    vec_t vecs[10];

    initial begin
        int cyc, prev_busy;
        logic seen, en_ok, stable;

        vecs[0] = '{3'd0, 32'd7,          32'd6,          1'b0, 32'd42,         3};
        vecs[1] = '{3'd1, 32'h8000_0000,  32'h8000_0000,  1'b0, 32'h4000_0000,  4};
        vecs[2] = '{3'd2, 32'hFFFF_FFFF,  32'd2,          1'b0, 32'hFFFF_FFFF,  4};
        vecs[3] = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'hFFFF_FFFE,  4};
        vecs[4] = '{3'd5, 32'd100,        32'd7,          1'b0, 32'd14,         37};
        vecs[5] = '{3'd7, 32'd100,        32'd7,          1'b0, 32'd2,          37};
        vecs[6] = '{3'd4, 32'hFFFF_FF9C,  32'd7,          1'b0, 32'hFFFF_FFF2,  37};
        vecs[7] = '{3'd6, 32'hFFFF_FF9C,  32'd7,          1'b0, 32'hFFFF_FFFE,  37};
        vecs[8] = '{3'd4, 32'd123,        32'd0,          1'b0, 32'hFFFF_FFFF,  2};
        vecs[9] = '{3'd6, 32'd5,          32'd0,          1'b1, 32'd5,          37};

        // Reset state
        repeat (2) @(negedge clk_i);
        check("rst_resp_valid", 68'(resp_valid_o), 68'd0);
        check("rst_result", 68'(resp_result_o), 68'd0);
        check("rst_busy_cycles", 68'(busy_cycles_o), 68'd0);
        check("rst_enables", 68'({md_mult_en_o, md_div_en_o, md_ready_id_o}), 68'd0);
        check("rst_imd", md_imd_val_q_o, 68'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Intermediate-value registers, per-half write enables
        md_imd_val_d_i = {34'h0, 34'h2_1234_5678}; md_imd_val_we_i = 2'b01;
        @(negedge clk_i);
        check("imd_lo_write", md_imd_val_q_o, {34'h0, 34'h2_1234_5678});
        md_imd_val_d_i = {34'h1_DEAD_BEEF, 34'h0}; md_imd_val_we_i = 2'b10;
        @(negedge clk_i);
        check("imd_hi_write", md_imd_val_q_o, {34'h1_DEAD_BEEF, 34'h2_1234_5678});
        md_imd_val_d_i = 68'd0; md_imd_val_we_i = 2'b00;
        @(negedge clk_i);
        check("imd_hold", md_imd_val_q_o, {34'h1_DEAD_BEEF, 34'h2_1234_5678});

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dit);
            check($sformatf("vec%0d_sel", i), 68'({md_mult_sel_o, md_div_sel_o}),
                  68'({~vecs[i].op[2], vecs[i].op[2]}));
            wait_resp(vecs[i].lat, vecs[i].res, $sformatf("vec%0d", i));
            finish_resp();
        end
        prev_busy = vecs[9].lat;

        // Flush in BUSY cycle 10 of a DIV: drains silently until the engine finishes
        issue(3'd4, 32'd1000, 32'd3, 1'b0);
        repeat (10) @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        cyc = 10; seen = 1'b0; en_ok = 1'b1;
        do begin
            @(negedge clk_i); cyc++;
            if (resp_valid_o) seen = 1'b1;
            if (!req_ready_o && !(md_div_en_o && md_ready_id_o)) en_ok = 1'b0;
        end while (!req_ready_o && cyc < 80);
        check("flush_ready_cycle", 68'(cyc), 68'd38);
        check("flush_no_resp", 68'(seen), 68'd0);
        check("flush_engine_kept_running", 68'(en_ok), 68'd1);
        check("flush_busy_unchanged", 68'(busy_cycles_o), 68'(prev_busy));
        issue(3'd0, 32'd3, 32'd3, 1'b0);
        wait_resp(3, 32'd9, "post_flush_mul");
        finish_resp();

        // Response stall, then back-to-back accept from RESP
        issue(3'd0, 32'd5, 32'd5, 1'b0);
        wait_resp(3, 32'd25, "stall_mul");
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            if (!resp_valid_o || resp_result_o != 32'd25) stable = 1'b0;
        end
        check("stall_result_stable", 68'(stable), 68'd1);
        resp_ready_i = 1'b1;
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        resp_ready_i = 1'b0;
        wait_resp(4, 32'hFFFF_FFFE, "b2b_mulhu");
        finish_resp();

        // Flush in RESP drops the response and suppresses a same-cycle accept
        issue(3'd0, 32'd2, 32'd2, 1'b0);
        wait_resp(3, 32'd4, "resp_flush_mul");
        flush_i = 1'b1; req_valid_i = 1'b1; req_op_i = 3'd0; resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0; req_valid_i = 1'b0; resp_ready_i = 1'b0;
        check("resp_flush_valid_dropped", 68'(resp_valid_o), 68'd0);
        check("resp_flush_no_accept", 68'({req_ready_o, md_mult_en_o}), 68'b10);

        // Asynchronous reset mid-divide
        issue(3'd4, 32'd50, 32'd5, 1'b0);
        repeat (5) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("midop_rst_enables", 68'({md_div_en_o, md_ready_id_o}), 68'd0);
        check("midop_rst_busy_cycles", 68'(busy_cycles_o), 68'd0);
        check("midop_rst_result", 68'(resp_result_o), 68'd0);
        check("midop_rst_imd", md_imd_val_q_o, 68'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        issue(3'd5, 32'd100, 32'd7, 1'b0);
        wait_resp(37, 32'd14, "post_rst_divu");
        finish_resp();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
